// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and coordinate type for the sync generator and renderers.
// No logic of its own.
// No flow control.
package vga_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // Horizontal timing in pixel ticks
  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

  // Vertical timing in lines
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Derived boundaries, typed to the coordinate width so compares stay width-clean
  localparam coord_t H_VIS_END    = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS_END    = coord_t'(V_DISPLAY);
  localparam coord_t H_LAST       = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST       = coord_t'(V_TOTAL - 1);
  localparam coord_t V_VIS_LAST   = coord_t'(V_DISPLAY - 1);
  localparam coord_t H_SYNC_FIRST = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t H_SYNC_LAST  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t V_SYNC_FIRST = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t V_SYNC_LAST  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_tick_gen.sv
// Pixel-rate enable: one-clk p_tick every CLK_DIV system clocks (constant high when CLK_DIV = 1).
// Registered output; first pulse on the CLK_DIV-th rising edge after rstn release.
// Free-running, no backpressure.
module vga_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rstn,
  output logic p_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  // Divider wraps at CLK_DIV-1; the pulse is registered off the terminal count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt <= '0;
      p_tick  <= 1'b0;
    end else begin
      div_cnt <= (div_cnt >= DIV_LAST) ? '0 : div_cnt + 1'b1;
      p_tick  <= (div_cnt >= DIV_LAST);
    end
  end

endmodule

// File: rtl/vga_sync.sv
// 640x480@60 sync generator: pixel/line counters, registered active-low hsync/vsync, video_on, frame_tick.
// Counters and syncs update on the same p_tick edge; video_on is combinational from the counters.
// Free-running, no backpressure. Define VGA_FRAME_TICK_EN to enable frame_tick (else tied to 0).
module vga_sync
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rstn,
  output logic               p_tick,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_tick
);

  coord_t x_q, y_q;
  coord_t x_nxt, y_nxt;
  logic   hsync_nxt, vsync_nxt;

  vga_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk    (clk),
    .rstn   (rstn),
    .p_tick (p_tick)
  );

  // Next counter values; >= compares keep the counters in range even from a corrupted state
  always_comb begin
    x_nxt = x_q;
    y_nxt = y_q;
    if (p_tick) begin
      if (x_q >= H_LAST) begin
        x_nxt = '0;
        y_nxt = (y_q >= V_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_nxt = x_q + 1'b1;
      end
    end
    hsync_nxt = !in_window(x_nxt, H_SYNC_FIRST, H_SYNC_LAST);
    vsync_nxt = !in_window(y_nxt, V_SYNC_FIRST, V_SYNC_LAST);
  end

  // Counters and syncs registered together so sync edges line up with the count they describe
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_q   <= '0;
      y_q   <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      x_q   <= x_nxt;
      y_q   <= y_nxt;
      hsync <= hsync_nxt;
      vsync <= vsync_nxt;
    end
  end

`ifdef VGA_FRAME_TICK_EN
  // Pulse on the edge that steps from (799,479) into (0,480), the start of vertical blanking
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= p_tick && (x_q == H_LAST) && (y_q == V_VIS_LAST);
    end
  end
`else
  assign frame_tick = 1'b0;
`endif

  assign pixel_x  = x_q;
  assign pixel_y  = y_q;
  assign video_on = (x_q < H_VIS_END) && (y_q < V_VIS_END);

endmodule
